// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// one-hot lt/eq/gt result word.
package cmp_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } result_t;

   localparam result_t RES_NONE = 3'b000;
   localparam result_t RES_LT   = 3'b100;
   localparam result_t RES_EQ   = 3'b010;
   localparam result_t RES_GT   = 3'b001;

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned comparator for one digit of the serial scan.
module cmp_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   assign lt = (a < b);
   assign eq = (a == b);
   assign gt = (a > b);

endmodule

// File: rtl/mag_cmp_serial.sv
// Sequential magnitude comparator: scans operands MS digit first, DIGIT bits
// per cycle, terminating on the first differing digit.
module mag_cmp_serial
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int N  = WIDTH / DIGIT;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0]    K_TOP    = KW'(N - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   generate
      if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
         $error("mag_cmp_serial: WIDTH must be a non-zero multiple of DIGIT");
      end
   endgenerate

   state_t           state_reg, state_next;
   logic [KW-1:0]    k_reg, k_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   result_t          res_reg, res_next;
   logic             done_reg, done_next;

   logic [DIGIT-1:0] a_dig, b_dig;
   logic             d_lt, d_eq, d_gt;

   assign a_dig = a_reg[int'(k_reg)*DIGIT +: DIGIT];
   assign b_dig = b_reg[int'(k_reg)*DIGIT +: DIGIT];

   cmp_digit #(.DIGIT(DIGIT)) u_digit (
      .a  (a_dig),
      .b  (b_dig),
      .lt (d_lt),
      .eq (d_eq),
      .gt (d_gt)
   );

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      res_next   = res_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               // Flipping the sign bit maps two's complement onto offset
               // binary, so the same unsigned scan yields the signed order.
               a_next     = signed_mode ? (a ^ MSB_MASK) : a;
               b_next     = signed_mode ? (b ^ MSB_MASK) : b;
               k_next     = K_TOP;
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (!d_eq) begin
               res_next   = d_lt ? RES_LT : (d_gt ? RES_GT : RES_NONE);
               done_next  = 1'b1;
               state_next = IDLE;
            end else if (k_reg == '0) begin
               res_next   = RES_EQ;
               done_next  = 1'b1;
               state_next = IDLE;
            end else begin
               k_next = k_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         k_reg     <= K_TOP;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= RES_NONE;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         res_reg   <= res_next;
         done_reg  <= done_next;
      end
   end

   assign busy = (state_reg == SCAN);
   assign done = done_reg;
   assign lt   = res_reg.lt;
   assign eq   = res_reg.eq;
   assign gt   = res_reg.gt;

endmodule

// File: tb/tb_mag_cmp_serial.sv
// Scoreboard bench for mag_cmp_serial (WIDTH=16, DIGIT=4): driver pushes
// expected {lt,eq,gt} and latency, a monitor pops and checks on each done.
module tb_mag_cmp_serial;
   import cmp_pkg::*;

   localparam int WIDTH = 16;
   localparam int DIGIT = 4;
   localparam int N     = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] a, b;
   logic             busy, done, lt, eq, gt;

   mag_cmp_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .lt          (lt),
      .eq          (eq),
      .gt          (gt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] res;
      int         m;
      int         e0;
      string      name;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sm;
      logic [2:0]  res;
      int          m;
      string       name;
   } vec_t;

   exp_t       scb[$];
   int         cyc      = 0;
   int         checks   = 0;
   int         errors   = 0;
   int         busy_cnt = 0;
   logic [2:0] last_exp = 3'b000;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: runs on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_cnt = 0;
         last_exp = 3'b000;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (scb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
               e = scb.pop_front();
               check({e.name, "_res"}, {29'd0, lt, eq, gt}, {29'd0, e.res});
               check({e.name, "_lat"}, cyc - e.e0, e.m);
               check({e.name, "_busy"}, busy_cnt, e.m);
               $display("txn %s: ltegt=%b lat=%0d busy=%0d (exp %b/%0d)",
                        e.name, {lt, eq, gt}, cyc - e.e0, busy_cnt, e.res, e.m);
               last_exp = e.res;
            end
            busy_cnt = 0;
         end else if (scb.size() > 0 && (cyc - scb[0].e0) > 2 * N + 4) begin
            e = scb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", e.name);
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   // Call at a falling edge. Holds start for one cycle.
   task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vsm,
                        input logic [2:0] res, input int m, input string name);
      exp_t e;
      wait_idle();
      a           = va;
      b           = vb;
      signed_mode = vsm;
      start       = 1'b1;
      e.res  = res;
      e.m    = m;
      e.e0   = cyc + 1;
      e.name = name;
      scb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      if (m > 1) check({name, "_hold"}, {29'd0, lt, eq, gt}, {29'd0, last_exp});
   endtask

   task automatic drain();
      int t = 0;
      while ((scb.size() > 0 || busy) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (scb.size() > 0) check("drain_timeout", 32'd1, 32'd0);
   endtask

   vec_t dir[] = '{
      '{16'h1234, 16'h1234, 1'b0, RES_EQ, 4, "eq_u"},
      '{16'h12A4, 16'h12B4, 1'b0, RES_LT, 3, "mid_lt"},
      '{16'h12B5, 16'h12B4, 1'b0, RES_GT, 4, "low_gt"},
      '{16'h8000, 16'h7FFF, 1'b0, RES_GT, 1, "top_u"},
      '{16'h8000, 16'h7FFF, 1'b1, RES_LT, 1, "top_s"},
      '{16'hFFFF, 16'h0000, 1'b1, RES_LT, 1, "neg1_s"},
      '{16'hFFFF, 16'h0000, 1'b0, RES_GT, 1, "ffff_u"},
      '{16'h0000, 16'h0000, 1'b1, RES_EQ, 4, "zero_s"},
      '{16'hFFFE, 16'hFFFF, 1'b1, RES_LT, 4, "m2m1_s"},
      '{16'h7FFF, 16'h8000, 1'b1, RES_GT, 1, "max_min_s"},
      '{16'h0010, 16'h0001, 1'b0, RES_GT, 3, "d1_gt"},
      '{16'h8001, 16'h8002, 1'b1, RES_LT, 4, "neg_lsd_s"}
   };

   initial begin
      logic [15:0] ra, rb;
      logic        rsm;
      logic [2:0]  rres;
      int          rm, t;

      rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_lt",   {31'd0, lt},   32'd0);
      check("rst_eq",   {31'd0, eq},   32'd0);
      check("rst_gt",   {31'd0, gt},   32'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (dir[i]) issue(dir[i].a, dir[i].b, dir[i].sm, dir[i].res, dir[i].m, dir[i].name);
      drain();

      // start during SCAN must be ignored; operands stay captured
      issue(16'h1234, 16'h1234, 1'b0, RES_EQ, 4, "ign_first");
      a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // start asserted in the done cycle is accepted
      issue(16'h12A4, 16'h12B4, 1'b0, RES_LT, 3, "b2b_first");
      t = 0;
      while (!done && t < 20) begin
         @(negedge clk);
         t++;
      end
      issue(16'h8000, 16'h7FFF, 1'b1, RES_LT, 1, "b2b_second");
      drain();

      // reset in the second SCAN cycle aborts without a done
      a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_res",  {29'd0, lt, eq, gt}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (10) @(negedge clk);

      // reset and start together: reset wins
      rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0002;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rst_start_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("rst_start_busy2", {31'd0, busy}, 32'd0);
      issue(16'h1234, 16'h1234, 1'b0, RES_EQ, 4, "post_rst_eq");
      drain();

      // randomized regression against a direct signed/unsigned compare
      for (int i = 0; i < 2000; i++) begin
         ra  = 16'($urandom);
         rb  = (i % 4 == 0) ? ra ^ 16'($urandom_range(0, 15)) : 16'($urandom);
         rsm = 1'($urandom_range(0, 1));
         if (rsm) rres = ($signed(ra) < $signed(rb)) ? RES_LT :
                         ($signed(ra) > $signed(rb)) ? RES_GT : RES_EQ;
         else     rres = (ra < rb) ? RES_LT : (ra > rb) ? RES_GT : RES_EQ;
         rm = N;
         for (int k = N - 1; k >= 0; k--) begin
            if (ra[k*DIGIT +: DIGIT] != rb[k*DIGIT +: DIGIT]) begin
               rm = N - k;
               break;
            end
         end
         issue(ra, rb, rsm, rres, rm, $sformatf("rnd%0d", i));
      end
      drain();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
